// File: rtl/unidade_desvio_pkg.sv
// Shared definitions for the CatCORE branch unit: condition codes and FSM state encoding.
package unidade_desvio_pkg;

  localparam logic [2:0] COND_SEMPRE      = 3'b000;
  localparam logic [2:0] COND_ZERO        = 3'b001;
  localparam logic [2:0] COND_NAO_ZERO    = 3'b010;
  localparam logic [2:0] COND_NEG         = 3'b011;
  localparam logic [2:0] COND_NAO_NEG     = 3'b100;
  localparam logic [2:0] COND_ZERO_OU_NEG = 3'b101;
  localparam logic [2:0] COND_POSITIVO    = 3'b110;
  localparam logic [2:0] COND_PARA        = 3'b111;

  typedef enum logic [1:0] {
    EST_EXEC   = 2'd0,
    EST_ESPERA = 2'd1,
    EST_PARADO = 2'd2
  } estado_t;

endpackage

// File: rtl/unidade_desvio_avalia_condicao.sv
// Combinational condition evaluator: decides whether a condition code holds for the ALU flags.
module avalia_condicao
  import unidade_desvio_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       sinal_ZERO,
  input  logic       sinal_NEG,
  output logic       verdadeiro
);

  always_comb begin
    verdadeiro = 1'b0;
    case (cond)
      COND_SEMPRE:      verdadeiro = 1'b1;
      COND_ZERO:        verdadeiro = sinal_ZERO;
      COND_NAO_ZERO:    verdadeiro = ~sinal_ZERO;
      COND_NEG:         verdadeiro = sinal_NEG;
      COND_NAO_NEG:     verdadeiro = ~sinal_NEG;
      COND_ZERO_OU_NEG: verdadeiro = sinal_ZERO | sinal_NEG;
      COND_POSITIVO:    verdadeiro = ~sinal_ZERO & ~sinal_NEG;
      // HALT is never a branch-taking condition
      default:          verdadeiro = 1'b0;
    endcase
  end

endmodule

// File: rtl/unidade_desvio.sv
// Program counter and branch resolution for CatCORE; conditional branches wait one
// cycle so the ALU's registered flags line up with the evaluation edge.
//
// state      | meaning
// EST_EXEC   | normal execution: step, branch or halt requests accepted
// EST_ESPERA | conditional branch latched, flags evaluated on exit edge
// EST_PARADO | halted, only reset leaves
module unidade_desvio
  import unidade_desvio_pkg::*;
#(
  parameter int PC_WIDTH = 10,
  parameter int RESET_PC = 0
) (
  input  logic                clockAuto,
  input  logic                reset,
  input  logic                avancar,
  input  logic                desvio_valido,
  input  logic [2:0]          cond,
  input  logic [PC_WIDTH-1:0] alvo,
  input  logic                sinal_ZERO,
  input  logic                sinal_NEG,
  output logic [PC_WIDTH-1:0] pc,
  output logic                ocupado,
  output logic                desvio_tomado,
  output logic                parado
);

  localparam logic [PC_WIDTH-1:0] PC_INICIAL = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] UM         = PC_WIDTH'(1);

  estado_t             estado;
  logic [2:0]          cond_lat;
  logic [PC_WIDTH-1:0] alvo_lat;
  logic                verdadeiro;

  avalia_condicao u_avalia (
    .cond       (cond_lat),
    .sinal_ZERO (sinal_ZERO),
    .sinal_NEG  (sinal_NEG),
    .verdadeiro (verdadeiro)
  );

  always_ff @(posedge clockAuto) begin
    if (reset) begin
      estado        <= EST_EXEC;
      pc            <= PC_INICIAL;
      desvio_tomado <= 1'b0;
      cond_lat      <= COND_SEMPRE;
      alvo_lat      <= '0;
    end else begin
      desvio_tomado <= 1'b0;
      case (estado)
        EST_EXEC: begin
          if (desvio_valido) begin
            if (cond == COND_SEMPRE) begin
              pc            <= alvo;
              desvio_tomado <= 1'b1;
            end else if (cond == COND_PARA) begin
              estado <= EST_PARADO;
            end else begin
              cond_lat <= cond;
              alvo_lat <= alvo;
              estado   <= EST_ESPERA;
            end
          end else if (avancar) begin
            pc <= pc + UM;
          end
        end
        EST_ESPERA: begin
          if (verdadeiro) begin
            pc            <= alvo_lat;
            desvio_tomado <= 1'b1;
          end else begin
            pc <= pc + UM;
          end
          estado <= EST_EXEC;
        end
        EST_PARADO: ;
        // unused encoding recovers to normal execution
        default: estado <= EST_EXEC;
      endcase
    end
  end

  assign ocupado = (estado == EST_ESPERA);
  assign parado  = (estado == EST_PARADO);

endmodule

// File: tb/tb_unidade_desvio.sv
// Directed plus randomized bench for unidade_desvio with a cycle-level reference model.
module tb_unidade_desvio;

  logic       clockAuto = 1'b0;
  logic       reset = 1'b0;
  logic       avancar = 1'b0;
  logic       desvio_valido = 1'b0;
  logic [2:0] cond = 3'd0;
  logic [3:0] alvo = 4'd0;
  logic       sinal_ZERO = 1'b0;
  logic       sinal_NEG = 1'b0;
  logic [3:0] pc;
  logic       ocupado;
  logic       desvio_tomado;
  logic       parado;

  int tests = 0;
  int fails = 0;

  // reference model state
  int m_pc = 0;
  bit m_wait = 0;
  bit m_halt = 0;
  bit m_taken = 0;
  int m_cond = 0;
  int m_alvo = 0;

  unidade_desvio #(.PC_WIDTH(4), .RESET_PC(0)) dut (
    .clockAuto     (clockAuto),
    .reset         (reset),
    .avancar       (avancar),
    .desvio_valido (desvio_valido),
    .cond          (cond),
    .alvo          (alvo),
    .sinal_ZERO    (sinal_ZERO),
    .sinal_NEG     (sinal_NEG),
    .pc            (pc),
    .ocupado       (ocupado),
    .desvio_tomado (desvio_tomado),
    .parado        (parado)
  );

  always #5 clockAuto = ~clockAuto;

  function automatic bit holds(int c, bit z, bit n);
    case (c)
      0: return 1;
      1: return z;
      2: return !z;
      3: return n;
      4: return !n;
      5: return z || n;
      6: return !z && !n;
      default: return 0;
    endcase
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_pc = 0; m_wait = 0; m_halt = 0; m_taken = 0;
    end else if (m_halt) begin
      m_taken = 0;
    end else if (m_wait) begin
      m_taken = holds(m_cond, sinal_ZERO, sinal_NEG);
      m_pc = m_taken ? m_alvo : (m_pc + 1) % 16;
      m_wait = 0;
    end else if (desvio_valido) begin
      m_taken = 0;
      if (cond == 3'd0) begin
        m_pc = alvo; m_taken = 1;
      end else if (cond == 3'd7) begin
        m_halt = 1;
      end else begin
        m_wait = 1; m_cond = cond; m_alvo = alvo;
      end
    end else begin
      m_taken = 0;
      if (avancar) m_pc = (m_pc + 1) % 16;
    end
  endtask

  task automatic check(input string tag);
    tests++;
    assert (pc === 4'(m_pc)) else begin
      fails++; $error("FAIL %s pc: got %0d expected %0d", tag, pc, m_pc);
    end
    tests++;
    assert (ocupado === m_wait) else begin
      fails++; $error("FAIL %s ocupado: got %b expected %b", tag, ocupado, m_wait);
    end
    tests++;
    assert (desvio_tomado === m_taken) else begin
      fails++; $error("FAIL %s desvio_tomado: got %b expected %b", tag, desvio_tomado, m_taken);
    end
    tests++;
    assert (parado === m_halt) else begin
      fails++; $error("FAIL %s parado: got %b expected %b", tag, parado, m_halt);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic av, input logic dv,
                      input logic [2:0] c, input logic [3:0] a, input logic z, input logic n);
    reset = r; avancar = av; desvio_valido = dv; cond = c; alvo = a;
    sinal_ZERO = z; sinal_NEG = n;
    @(posedge clockAuto);
    model_edge();
    #1;
    check(tag);
  endtask

  initial begin
    #2;
    step("reset", 1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 17; i++) step("wrap", 0, 1, 0, 0, 0, 0, 0);
    tests++;
    assert (pc === 4'd1) else begin
      fails++; $error("FAIL wrap_end pc: got %0d expected 1", pc);
    end

    step("br_always", 0, 1, 1, 3'b000, 4'd9, 0, 0);
    tests++;
    assert (pc === 4'd9 && desvio_tomado === 1'b1) else begin
      fails++; $error("FAIL br_always_abs pc/tomado: got %0d/%b expected 9/1", pc, desvio_tomado);
    end
    step("br_always_pulse", 0, 0, 0, 0, 0, 0, 0);

    // pc=3, cond ZERO taken then not taken
    step("reset", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("to3", 0, 1, 0, 0, 0, 0, 0);
    step("z_req", 0, 0, 1, 3'b001, 4'd12, 0, 0);
    step("z_esp", 0, 1, 1, 3'b000, 4'd7, 1, 0);
    tests++;
    assert (pc === 4'd12 && desvio_tomado === 1'b1) else begin
      fails++; $error("FAIL z_taken_abs pc/tomado: got %0d/%b expected 12/1", pc, desvio_tomado);
    end
    step("reset", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("to3", 0, 1, 0, 0, 0, 0, 0);
    step("nz_req", 0, 0, 1, 3'b001, 4'd12, 0, 0);
    step("nz_esp", 0, 0, 0, 0, 0, 0, 0);
    tests++;
    assert (pc === 4'd4 && desvio_tomado === 1'b0) else begin
      fails++; $error("FAIL z_not_taken_abs pc/tomado: got %0d/%b expected 4/0", pc, desvio_tomado);
    end

    // every conditional code against every flag combination, back to back
    for (int c = 1; c < 7; c++)
      for (int f = 0; f < 4; f++) begin
        step("cc_req", 0, 0, 1, 3'(c), 4'($urandom_range(0, 15)), 0, 0);
        step("cc_esp", 0, 0, 0, 0, 0, f[1], f[0]);
      end

    // halt, frozen against requests, then reset
    step("halt", 0, 0, 1, 3'b111, 4'd3, 0, 0);
    for (int i = 0; i < 10; i++)
      step("halted", 0, 1, 1, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 0, 0);
    step("halt_reset", 1, 0, 0, 0, 0, 0, 0);
    tests++;
    assert (pc === 4'd0 && parado === 1'b0) else begin
      fails++; $error("FAIL halt_reset_abs pc/parado: got %0d/%b expected 0/0", pc, parado);
    end

    // reset during ESPERA aborts the pending branch
    for (int i = 0; i < 5; i++) step("to5", 0, 1, 0, 0, 0, 0, 0);
    step("ab_req", 0, 0, 1, 3'b001, 4'd10, 0, 0);
    step("ab_reset", 1, 0, 0, 0, 0, 1, 0);
    step("ab_after", 0, 0, 0, 0, 0, 1, 0);
    tests++;
    assert (pc === 4'd0 && desvio_tomado === 1'b0 && ocupado === 1'b0) else begin
      fails++; $error("FAIL abort_abs pc/tomado/ocupado: got %0d/%b/%b expected 0/0/0", pc, desvio_tomado, ocupado);
    end

    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom),
           3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
